// File: rtl/mem_access_ctrl_if.sv
// Bundle between the EX/MEM pipeline, the MEM-stage load/store controller and the data memory.
// The controller takes the slave view; the pipeline/memory environment takes the master view.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic [1:0]        reqSize;
  logic              reqSigned;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;

  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;

  logic              respValid;
  logic [DATA_W-1:0] respData;
  logic              misaligned;

  modport slave (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memReadData,
    output reqReady, memRead, memWrite, memAddress, memWriteData,
    output respValid, respData, misaligned
  );

  modport master (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memReadData,
    input  reqReady, memRead, memWrite, memAddress, memWriteData,
    input  respValid, respData, misaligned
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: word-indexed data-memory accesses, read-modify-write for
// sub-word stores, sign/zero-extended load results and misaligned-request flagging.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, ERR} state_t;

  state_t            state, state_nxt;
  logic              accept, misalign_req;
  logic [ADDR_W-1:0] addr_sel;

  logic              req_signed_p0;
  logic [1:0]        req_size_p0;
  logic [ADDR_W-1:0] req_addr_p0;
  logic [DATA_W-1:0] req_data_p0;
  logic [DATA_W-1:0] merge_p1, merge_nxt;

  logic              mem_read_q, mem_write_q, resp_valid_q, misaligned_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_wdata_q, resp_data_q;
  logic              mem_read_nxt, mem_write_nxt, resp_valid_nxt, misaligned_nxt;
  logic [ADDR_W-1:0] mem_address_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, resp_data_nxt;

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size,
                                                    input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*int'(lane) +: 8];
    h = word[16*int'(lane[1]) +: 16];
    case (size)
      2'b00:   return {{(DATA_W-8){sgn & b[7]}}, b};
      2'b01:   return {{(DATA_W-16){sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size);
    logic [DATA_W-1:0] w;
    w = word;
    if (size == 2'b00) w[8*int'(lane) +: 8] = data[7:0];
    else               w[16*int'(lane[1]) +: 16] = data[15:0];
    return w;
  endfunction

  always_comb begin
    state_nxt      = state;
    accept         = bus.reqValid && (state == IDLE);
    addr_sel       = (state == IDLE) ? bus.reqAddr : req_addr_p0;
    merge_nxt      = store_merge(bus.memReadData, req_data_p0, req_addr_p0[1:0], req_size_p0);
    mem_read_nxt   = 1'b0;
    mem_write_nxt  = 1'b0;
    mem_address_nxt = '0;
    mem_wdata_nxt  = '0;
    resp_valid_nxt = 1'b0;
    resp_data_nxt  = resp_data_q;
    misaligned_nxt = 1'b0;

    case (bus.reqSize)
      2'b00:   misalign_req = 1'b0;
      2'b01:   misalign_req = bus.reqAddr[0];
      default: misalign_req = |bus.reqAddr[1:0];
    endcase

    case (state)
      IDLE: begin
        if (accept) begin
          if (misalign_req)       state_nxt = ERR;
          else if (!bus.reqWrite) state_nxt = LOAD;
          else if (bus.reqSize[1]) state_nxt = WRITE;
          else                    state_nxt = RMW_READ;
        end
      end
      LOAD: begin
        state_nxt      = IDLE;
        resp_valid_nxt = 1'b1;
        resp_data_nxt  = load_extend(bus.memReadData, req_addr_p0[1:0], req_size_p0, req_signed_p0);
      end
      WRITE: begin
        state_nxt      = IDLE;
        resp_valid_nxt = 1'b1;
        resp_data_nxt  = req_data_p0;
      end
      RMW_READ: begin
        state_nxt     = RMW_WRITE;
        mem_wdata_nxt = merge_nxt;
      end
      RMW_WRITE: begin
        state_nxt      = IDLE;
        resp_valid_nxt = 1'b1;
        resp_data_nxt  = merge_p1;
      end
      ERR: begin
        state_nxt      = IDLE;
        resp_valid_nxt = 1'b1;
        resp_data_nxt  = '0;
        misaligned_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Strobes are decoded from the next state so they leave a flop for the whole access cycle
    mem_read_nxt  = (state_nxt == LOAD) || (state_nxt == RMW_READ);
    mem_write_nxt = (state_nxt == WRITE) || (state_nxt == RMW_WRITE);
    if (mem_read_nxt || mem_write_nxt) mem_address_nxt = {2'b00, addr_sel[ADDR_W-1:2]};
    if (state_nxt == WRITE) mem_wdata_nxt = bus.reqData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // p0: request captured at accept; p1: merged word captured during the RMW read
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr_p0   <= bus.reqAddr;
      req_data_p0   <= bus.reqData;
      req_size_p0   <= bus.reqSize;
      req_signed_p0 <= bus.reqSigned;
    end
    if (state == RMW_READ) merge_p1 <= merge_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      mem_read_q    <= mem_read_nxt;
      mem_write_q   <= mem_write_nxt;
      mem_address_q <= mem_address_nxt;
      mem_wdata_q   <= mem_wdata_nxt;
      resp_valid_q  <= resp_valid_nxt;
      resp_data_q   <= resp_data_nxt;
      misaligned_q  <= misaligned_nxt;
    end
  end

  assign bus.reqReady     = (state == IDLE);
  assign bus.memRead      = mem_read_q;
  assign bus.memWrite     = mem_write_q;
  assign bus.memAddress   = mem_address_q;
  assign bus.memWriteData = mem_wdata_q;
  assign bus.respValid    = resp_valid_q;
  assign bus.respData     = resp_data_q;
  assign bus.misaligned   = misaligned_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of single requests plus hand-written
// back-to-back and mid-operation reset sequences, against a small word memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  assign bus.memReadData = mem[bus.memAddress[3:0]];

  always @(posedge clk) begin
    if (bus.memWrite) mem[bus.memAddress[3:0]] <= bus.memWriteData;
    if (pre_en)       mem[pre_idx] <= pre_val;
  end

  int          rd_cnt = 0, wr_cnt = 0, rv_cnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic        overlap = 1'b0;

  always @(negedge clk) begin
    if (bus.memRead)  begin rd_cnt = rd_cnt + 1; last_addr = bus.memAddress; end
    if (bus.memWrite) begin wr_cnt = wr_cnt + 1; last_addr = bus.memAddress; last_wdata = bus.memWriteData; end
    if (bus.memRead && bus.memWrite) overlap = 1'b1;
    if (bus.respValid) rv_cnt = rv_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL t%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
    logic [31:0] init;
    logic [31:0] exp_resp;
    logic        exp_mis;
    int          exp_rd;
    int          exp_wr;
    int          exp_lat;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[14];

  task automatic preload(input int idx, input logic [31:0] val);
    pre_idx = idx[3:0];
    pre_val = val;
    pre_en  = 1'b1;
    @(posedge clk); #1;
    pre_en  = 1'b0;
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] data);
    bus.reqValid  = 1'b1;
    bus.reqWrite  = wr;
    bus.reqSize   = size;
    bus.reqSigned = sgn;
    bus.reqAddr   = addr;
    bus.reqData   = data;
  endtask

  task automatic do_vec(input int id, input vec_t v);
    int rd0, wr0, rv0, lat;
    preload(v.idx, v.init);
    @(negedge clk); #1;
    rd0 = rd_cnt; wr0 = wr_cnt; rv0 = rv_cnt;
    chk(id, "ready_idle", 32'(bus.reqReady), 32'd1);
    drive_req(v.wr, v.size, v.sgn, v.addr, v.data);
    @(posedge clk);
    @(negedge clk); #1;
    bus.reqValid = 1'b0;
    lat = 1;
    while (rv_cnt == rv0 && lat < 8) begin
      @(negedge clk); #1;
      lat = lat + 1;
    end
    if (rv_cnt == rv0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL t%0d resp_timeout: got no respValid within %0d cycles expected latency %0d", id, lat, v.exp_lat);
    end else begin
      chk(id, "latency", 32'(lat), 32'(v.exp_lat));
      chk(id, "resp_data", bus.respData, v.exp_resp);
      chk(id, "misaligned", 32'(bus.misaligned), 32'(v.exp_mis));
      chk(id, "ready_at_resp", 32'(bus.reqReady), 32'd1);
      chk(id, "rd_count", 32'(rd_cnt - rd0), 32'(v.exp_rd));
      chk(id, "wr_count", 32'(wr_cnt - wr0), 32'(v.exp_wr));
      if (v.exp_rd + v.exp_wr > 0) chk(id, "mem_addr", last_addr, 32'(v.idx));
      if (v.exp_wr > 0) chk(id, "write_data", last_wdata, v.exp_mem);
      @(negedge clk); #1;
      chk(id, "resp_pulse", 32'(rv_cnt - rv0), 32'd1);
      chk(id, "resp_hold", bus.respData, v.exp_resp);
      chk(id, "mem_word", mem[v.idx], v.exp_mem);
      chk(id, "no_overlap", 32'(overlap), 32'd0);
    end
  endtask

  initial begin
    //           wr    size   sgn   addr      data          idx init          resp          mis  rd wr lat mem
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,          1, 32'h10654321, 32'h10654321, 1'b0, 1, 0, 2, 32'h10654321};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0F, 32'h0,          3, 32'h8C123456, 32'hFFFFFF8C, 1'b0, 1, 0, 2, 32'h8C123456};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0F, 32'h0,          3, 32'h8C123456, 32'h0000008C, 1'b0, 1, 0, 2, 32'h8C123456};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h0C, 32'h0,          3, 32'h8C123456, 32'h00000056, 1'b0, 1, 0, 2, 32'h8C123456};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h1A, 32'h0,          6, 32'hAD654321, 32'hFFFFAD65, 1'b0, 1, 0, 2, 32'hAD654321};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h18, 32'h0,          6, 32'hAD654321, 32'h00004321, 1'b0, 1, 0, 2, 32'hAD654321};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h0D, 32'h000000AB,   3, 32'h8C123456, 32'h8C12AB56, 1'b0, 1, 1, 3, 32'h8C12AB56};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h06, 32'hDEADBEEF,   1, 32'h10654321, 32'h00000000, 1'b1, 0, 0, 2, 32'h10654321};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hCAFEF00D,   2, 32'h11111111, 32'hCAFEF00D, 1'b0, 0, 1, 2, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h1E, 32'h0000BEEF,   7, 32'h01234567, 32'hBEEF4567, 1'b0, 1, 1, 3, 32'hBEEF4567};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h13, 32'h0,          4, 32'h55AA55AA, 32'h00000000, 1'b1, 0, 0, 2, 32'h55AA55AA};
    vecs[11] = '{1'b0, 2'd3, 1'b1, 32'h04, 32'h0,          1, 32'h10654321, 32'h10654321, 1'b0, 1, 0, 2, 32'h10654321};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0E, 32'h0,          3, 32'h8C123456, 32'h00000012, 1'b0, 1, 0, 2, 32'h8C123456};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h0C, 32'hFFFFFF77,   3, 32'h8C123456, 32'h8C123477, 1'b0, 1, 1, 3, 32'h8C123477};

    rst_n = 1'b0;
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'd0;
    bus.reqSigned = 1'b0; bus.reqAddr = '0; bus.reqData = '0;
    repeat (3) @(negedge clk);
    #1;
    chk(100, "rst_strobes", 32'({bus.memRead, bus.memWrite}), 32'd0);
    chk(100, "rst_mem_addr", bus.memAddress, 32'd0);
    chk(100, "rst_mem_wdata", bus.memWriteData, 32'd0);
    chk(100, "rst_resp", 32'({bus.respValid, bus.misaligned}), 32'd0);
    chk(100, "rst_resp_data", bus.respData, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk(100, "rst_ready", 32'(bus.reqReady), 32'd1);

    for (int i = 0; i < 14; i++) do_vec(i, vecs[i]);

    // Back-to-back loads: second request held valid and accepted on the response edge
    begin
      int rd0, rv0;
      preload(1, 32'h10654321);
      preload(6, 32'hAD654321);
      @(negedge clk); #1;
      rd0 = rd_cnt; rv0 = rv_cnt;
      drive_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
      @(posedge clk);
      @(negedge clk); #1;
      drive_req(1'b0, 2'd1, 1'b1, 32'h1A, 32'h0);
      chk(200, "b2b_busy", 32'(bus.reqReady), 32'd0);
      @(negedge clk); #1;
      chk(200, "b2b_first_valid", 32'(bus.respValid), 32'd1);
      chk(200, "b2b_first_data", bus.respData, 32'h10654321);
      chk(200, "b2b_ready", 32'(bus.reqReady), 32'd1);
      @(negedge clk); #1;
      bus.reqValid = 1'b0;
      chk(200, "b2b_gap", 32'(bus.respValid), 32'd0);
      chk(200, "b2b_second_read", 32'({bus.memRead, bus.memWrite}), 32'b10);
      chk(200, "b2b_second_addr", bus.memAddress, 32'd6);
      @(negedge clk); #1;
      chk(200, "b2b_second_valid", 32'(bus.respValid), 32'd1);
      chk(200, "b2b_second_data", bus.respData, 32'hFFFFAD65);
      chk(200, "b2b_resp_count", 32'(rv_cnt - rv0), 32'd2);
      chk(200, "b2b_read_count", 32'(rd_cnt - rd0), 32'd2);
    end

    // Reset asserted while the byte store is in its read phase
    begin
      int wr0;
      preload(3, 32'h8C123456);
      @(negedge clk); #1;
      wr0 = wr_cnt;
      drive_req(1'b1, 2'd0, 1'b0, 32'h0D, 32'h000000AB);
      @(posedge clk);
      @(negedge clk); #1;
      bus.reqValid = 1'b0;
      chk(300, "rmw_read_phase", 32'({bus.memRead, bus.memWrite}), 32'b10);
      rst_n = 1'b0;
      #1;
      chk(300, "reset_drops_strobes", 32'({bus.memRead, bus.memWrite}), 32'd0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin @(negedge clk); #1; end
      chk(300, "reset_no_write", 32'(wr_cnt - wr0), 32'd0);
      chk(300, "reset_word_kept", mem[3], 32'h8C123456);
      chk(300, "reset_ready", 32'(bus.reqReady), 32'd1);
      chk(300, "reset_resp_idle", 32'(bus.respValid), 32'd0);
    end
    do_vec(301, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
